// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: baud tick divider, frame FSM with timeout, FWFT byte FIFO
module uart_rx_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 54,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 200
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [DIV_W-1:0]         div_in,
    input  logic                     div_we,
    output logic                     sample_tick,
    input  logic                     rx_ready,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     m_valid,
    output logic [7:0]               m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overrun,
    output logic                     timeout,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE, S_WAIT} state_t;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_fill;
    logic             r_rx_valid_q;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_accept;
    logic             w_drop;

    state_t           r_state;
    state_t           w_state_nx;
    logic [7:0]       r_tcnt;
    logic [7:0]       w_tcnt_nx;
    logic [7:0]       w_tcnt_inc;
    logic             w_to_set;

    logic             r_overrun;
    logic             r_timeout;

    // Divisors 0 and 1 both mean "tick every cycle"; otherwise wrap at divisor-1.
    assign w_wrap = (r_div <= DIV_W'(1)) || (r_cnt >= r_div - DIV_W'(1));

    // Baud divider; the tick is registered so a load suppresses the tick in the following cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_div  <= DIV_W'(DEFAULT_DIV);
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (div_we) begin
            r_div  <= div_in;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    // Push on the rising edge of rx_valid; a full FIFO still accepts if the head leaves this cycle.
    assign w_push   = rx_valid & ~r_rx_valid_q;
    assign w_pop    = (r_fill != '0) & m_ready;
    assign w_full   = (r_fill == FW'(DEPTH));
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    // FIFO storage, pointers and occupancy; memory is cleared so m_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_rx_valid_q <= 1'b0;
        end else begin
            r_rx_valid_q <= rx_valid;
            if (w_accept) begin
                r_mem[r_wr_ptr] <= rx_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_fill <= r_fill + FW'(w_accept) - FW'(w_pop);
        end
    end

    // Frame FSM state and tick counter register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_tcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_tcnt  <= w_tcnt_nx;
        end
    end

    assign w_tcnt_inc = r_tcnt + 8'd1;

    // Frame progress: a capture beats both a false start and a timeout in ACTIVE.
    always_comb begin
        w_state_nx = r_state;
        w_tcnt_nx  = r_tcnt;
        w_to_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tcnt_nx = 8'd0;
                if (!rx_ready) w_state_nx = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_push) begin
                    w_state_nx = S_DONE;
                end else if (rx_ready) begin
                    w_state_nx = S_IDLE;
                    w_tcnt_nx  = 8'd0;
                end else if (r_tick) begin
                    if (w_tcnt_inc == 8'(TIMEOUT)) begin
                        w_to_set   = 1'b1;
                        w_state_nx = S_WAIT;
                    end else begin
                        w_tcnt_nx = w_tcnt_inc;
                    end
                end
            end
            S_DONE: begin
                if (!rx_valid && rx_ready) begin
                    w_state_nx = S_IDLE;
                    w_tcnt_nx  = 8'd0;
                end else if (!rx_valid && !rx_ready) begin
                    w_state_nx = S_ACTIVE;
                    w_tcnt_nx  = 8'd0;
                end
            end
            S_WAIT: begin
                w_tcnt_nx = 8'd0;
                if (rx_ready) w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tcnt_nx  = 8'd0;
            end
        endcase
    end

    // Sticky error flags; a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_drop)       r_overrun <= 1'b1;
            else if (clr_err) r_overrun <= 1'b0;
            if (w_to_set)     r_timeout <= 1'b1;
            else if (clr_err) r_timeout <= 1'b0;
        end
    end

    assign sample_tick = r_tick;
    assign m_valid     = (r_fill != '0);
    assign m_data      = r_mem[r_rd_ptr];
    assign fill        = r_fill;
    assign overrun     = r_overrun;
    assign timeout     = r_timeout;

endmodule
